// File: rtl/sprite_pkg.sv
// Purpose: shared sprite geometry, frame marker, pixel codes and loader state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sprite_pkg;

    localparam int SPRITE_W = 10;
    localparam int SPRITE_H = 10;
    localparam int NPIX     = SPRITE_W * SPRITE_H;
    localparam int NBYTES   = NPIX / 4;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Palette index stored per pixel; code 3 is unused by the readers.
    typedef enum logic [1:0] {
        PIX_BLACK = 2'd0,
        PIX_EDGE  = 2'd1,
        PIX_COLOR = 2'd2
    } pix_code_t;

    // Loader FSM encoding.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SLOT   = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_UNPACK = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_DRAIN  = 3'd5;

endpackage

// File: rtl/pixel_unpacker.sv
// Purpose: holds one data byte and presents its four 2-bit pixels LSB-first.
// Latency: pixel 0 visible the cycle after load; one pixel per step; o_last flags the 4th.
// Backpressure: none; the caller steps it only while it can write.
module pixel_unpacker (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_step,
    output logic [1:0] o_pix,
    output logic       o_last
);

    logic [7:0] sh_q, sh_d;
    logic [1:0] cnt_q, cnt_d;

    // Load restarts the pixel sequence; each step shifts the next pixel into bits [1:0].
    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (i_load) begin
            sh_d  = i_byte;
            cnt_d = 2'd0;
        end else if (i_step) begin
            sh_d  = {2'b00, sh_q[7:2]};
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Shift register and pixel counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sh_q  <= 8'd0;
            cnt_q <= 2'd0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_pix  = sh_q[1:0];
    assign o_last = (cnt_q == 2'd3);

endmodule

// File: rtl/wall_sprite_loader.sv
// Purpose: parses framed sprite images from a byte stream and writes 2-bit pixels into sprite RAM.
// Latency: first pixel write the cycle after a data byte is accepted; done/err one cycle after the last byte.
// Backpressure: o_byte_ready low for the 4 unpack cycles following each data byte.
module wall_sprite_loader
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int ADDR_W      = $clog2(NUM_SPRITES * NPIX)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    input  logic              i_abort,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [1:0]        o_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int PIX_W  = $clog2(NPIX + 1);
    localparam int SKIP_W = $clog2(NBYTES + 2);
    localparam int SLOT_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    logic [2:0]        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [7:0]        csum_q, csum_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [1:0]        wdata_q, wdata_d;

    logic              accept;
    logic              unp_load, unp_step, unp_last;
    logic [1:0]        unp_pix;
    logic              we_live;
    logic [ADDR_W-1:0] waddr_live;

    assign accept     = i_byte_valid & ready_q;
    assign we_live    = (state_q == ST_UNPACK);
    assign waddr_live = ADDR_W'(slot_q) * ADDR_W'(NPIX) + ADDR_W'(pix_q);

    pixel_unpacker u_unpacker (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (unp_load),
        .i_byte  (i_byte),
        .i_step  (unp_step),
        .o_pix   (unp_pix),
        .o_last  (unp_last)
    );

    // Frame parser: next state, counters, checksum, result pulses; abort forces IDLE silently.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        pix_d    = pix_q;
        csum_d   = csum_q;
        skip_d   = skip_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unp_load = 1'b0;
        unp_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && i_byte == SYNC_BYTE) state_d = ST_SLOT;
            end
            ST_SLOT: begin
                if (accept) begin
                    if (int'(i_byte) < NUM_SPRITES) begin
                        slot_d  = i_byte[SLOT_W-1:0];
                        pix_d   = '0;
                        csum_d  = 8'd0;
                        state_d = ST_DATA;
                    end else begin
                        // Bad slot: swallow the rest of the frame (data + checksum) unseen.
                        skip_d  = SKIP_W'(NBYTES + 1);
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    csum_d   = csum_q ^ i_byte;
                    unp_load = 1'b1;
                    state_d  = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                unp_step = 1'b1;
                pix_d    = pix_q + PIX_W'(1);
                if (unp_last) begin
                    state_d = (pix_q == PIX_W'(NPIX - 1)) ? ST_CHECK : ST_DATA;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    done_d  = (i_byte == csum_q);
                    err_d   = (i_byte != csum_q);
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    skip_d = skip_q - SKIP_W'(1);
                    if (skip_q == SKIP_W'(1)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (i_abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    // Ready follows the state we are entering; write port holds its last values between writes.
    always_comb begin
        ready_d = (state_d != ST_UNPACK);
        waddr_d = we_live ? waddr_live : waddr_q;
        wdata_d = we_live ? unp_pix : wdata_q;
    end

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            pix_q   <= '0;
            csum_q  <= 8'd0;
            skip_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 2'd0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            pix_q   <= pix_d;
            csum_q  <= csum_d;
            skip_q  <= skip_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_byte_ready = ready_q;
    assign o_we         = we_live;
    assign o_waddr      = we_live ? waddr_live : waddr_q;
    assign o_wdata      = we_live ? unp_pix : wdata_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_wall_sprite_loader.sv
// Purpose: self-checking bench for wall_sprite_loader: table frames, random frames, corner sequences.
// Latency: n/a.
// Backpressure: byte driver holds valid until ready is seen.
module tb_wall_sprite_loader;
    import sprite_pkg::*;

    localparam int NS = 4;
    localparam int AW = $clog2(NS * NPIX);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    byte_i;
    logic          valid;
    logic          ready;
    logic          abort;
    logic          we;
    logic [AW-1:0] waddr;
    logic [1:0]    wdata;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    wall_sprite_loader #(.NUM_SPRITES(NS)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_byte       (byte_i),
        .i_byte_valid (valid),
        .o_byte_ready (ready),
        .i_abort      (abort),
        .o_we         (we),
        .o_waddr      (waddr),
        .o_wdata      (wdata),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Write/pulse monitor sampled on the falling edge.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [1:0]    d;
    } wr_t;
    wr_t wr_q[$];
    int  done_cnt = 0;
    int  err_cnt  = 0;

    always @(negedge clk) begin
        if (we) wr_q.push_back('{a: waddr, d: wdata});
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    logic [7:0] fd [NBYTES];

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        byte_i = b;
        valid  = 1'b1;
        while (1) begin
            @(negedge clk);
            if (ready) break;
            waited++;
            if (waited > 20) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    // Sends a whole frame and compares against the expected pixel image and result pulse.
    task automatic run_frame(input string tag, input int slot, input logic [7:0] flip,
                             input int exp_w, input int exp_done, input int exp_err);
        int         wb, db, eb, bad, ea, ed;
        logic [7:0] cs;
        wb = wr_q.size();
        db = done_cnt;
        eb = err_cnt;
        cs = 8'd0;
        for (int i = 0; i < NBYTES; i++) cs ^= fd[i];
        send_byte(SYNC_BYTE);
        send_byte(8'(slot));
        for (int i = 0; i < NBYTES; i++) send_byte(fd[i]);
        send_byte(cs ^ flip);
        check({tag, " done_pulse"}, int'(done), exp_done);
        check({tag, " err_pulse"}, int'(err), exp_err);
        repeat (3) @(posedge clk);
        #1;
        check({tag, " busy_after"}, int'(busy), 0);
        check({tag, " write_count"}, wr_q.size() - wb, exp_w);
        if (exp_w == NPIX && wr_q.size() - wb == NPIX) begin
            bad = 0;
            for (int n = 0; n < NPIX; n++) begin
                ea = slot * NPIX + n;
                ed = (int'(fd[n / 4]) >> (2 * (n % 4))) & 3;
                if (int'(wr_q[wb + n].a) != ea || int'(wr_q[wb + n].d) != ed) bad++;
            end
            check({tag, " write_contents_bad"}, bad, 0);
        end
        check({tag, " done_count"}, done_cnt - db, exp_done);
        check({tag, " err_count"}, err_cnt - eb, exp_err);
    endtask

    typedef struct {
        int         slot;
        int         pat;     // 0: i*7, 1: all sync bytes, 2: random
        logic [7:0] flip;
        int         exp_w;
        int         exp_done;
        int         exp_err;
    } vec_t;

    initial begin
        vec_t vt [6];
        int   wb, db, eb;
        int   rslot, rdone;
        logic [7:0] rflip;

        rst_n  = 1'b0;
        valid  = 1'b0;
        abort  = 1'b0;
        byte_i = 8'd0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst we", int'(we), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst err", int'(err), 0);
        check("rst waddr", int'(waddr), 0);
        check("rst wdata", int'(wdata), 0);
        check("rst ready", int'(ready), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready after rst", int'(ready), 1);

        // Table of whole-frame vectors.
        vt[0] = '{slot: 2,   pat: 0, flip: 8'h00, exp_w: NPIX, exp_done: 1, exp_err: 0};
        vt[1] = '{slot: 2,   pat: 0, flip: 8'h01, exp_w: NPIX, exp_done: 0, exp_err: 1};
        vt[2] = '{slot: 5,   pat: 0, flip: 8'h00, exp_w: 0,    exp_done: 0, exp_err: 1};
        vt[3] = '{slot: 0,   pat: 1, flip: 8'h00, exp_w: NPIX, exp_done: 1, exp_err: 0};
        vt[4] = '{slot: 3,   pat: 2, flip: 8'h00, exp_w: NPIX, exp_done: 1, exp_err: 0};
        vt[5] = '{slot: 255, pat: 2, flip: 8'h00, exp_w: 0,    exp_done: 0, exp_err: 1};
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < NBYTES; i++) begin
                case (vt[v].pat)
                    0:       fd[i] = 8'(i * 7);
                    1:       fd[i] = SYNC_BYTE;
                    default: fd[i] = 8'($urandom_range(0, 255));
                endcase
            end
            run_frame($sformatf("vec%0d", v), vt[v].slot, vt[v].flip,
                      vt[v].exp_w, vt[v].exp_done, vt[v].exp_err);
        end

        // Junk before sync is dropped with ready held high.
        send_byte(8'h00);
        check("junk00 ready", int'(ready), 1);
        send_byte(8'hFF);
        check("junkFF ready", int'(ready), 1);
        send_byte(8'hA4);
        check("junkA4 ready", int'(ready), 1);
        check("junk busy", int'(busy), 0);
        for (int i = 0; i < NBYTES; i++) fd[i] = 8'(i * 3 + 1);
        run_frame("after_junk", 1, 8'h00, NPIX, 1, 0);

        // Abort during the 10th unpack: 9 full bytes plus one write in the abort cycle.
        wb = wr_q.size();
        db = done_cnt;
        eb = err_cnt;
        for (int i = 0; i < NBYTES; i++) fd[i] = 8'(i * 11);
        send_byte(SYNC_BYTE);
        send_byte(8'd1);
        for (int i = 0; i < 10; i++) send_byte(fd[i]);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort we", int'(we), 0);
        check("abort busy", int'(busy), 0);
        repeat (6) @(posedge clk);
        #1;
        check("abort writes", wr_q.size() - wb, 37);
        check("abort done", done_cnt - db, 0);
        check("abort err", err_cnt - eb, 0);
        for (int i = 0; i < NBYTES; i++) fd[i] = 8'($urandom_range(0, 255));
        run_frame("after_abort", 0, 8'h00, NPIX, 1, 0);

        // Reset mid-unpack with valid held.
        for (int i = 0; i < NBYTES; i++) fd[i] = 8'hC3;
        send_byte(SYNC_BYTE);
        send_byte(8'd3);
        send_byte(fd[0]);
        byte_i = 8'h00;
        valid  = 1'b1;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        check("midrst we", int'(we), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst ready", int'(ready), 0);
        check("midrst waddr", int'(waddr), 0);
        check("midrst wdata", int'(wdata), 0);
        check("midrst done", int'(done), 0);
        check("midrst err", int'(err), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst ready", int'(ready), 1);
        check("postrst busy", int'(busy), 0);
        valid = 1'b0;
        run_frame("after_rst", 3, 8'h00, NPIX, 1, 0);

        // Randomized frames against the reference rules.
        for (int r = 0; r < 8; r++) begin
            rslot = $urandom_range(0, 5);
            rflip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            for (int i = 0; i < NBYTES; i++) fd[i] = 8'($urandom_range(0, 255));
            rdone = (rslot < NS && rflip == 8'h00) ? 1 : 0;
            run_frame($sformatf("rnd%0d", r), rslot, rflip,
                      (rslot < NS) ? NPIX : 0, rdone, 1 - rdone);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
